// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (LS).
// LS wins by default; IF is forced after STARVE_LIMIT back-to-back LS grants, and a watchdog
// aborts any access left unacknowledged for TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // fetch requester
  input  logic                 if_req_i,
  input  logic [BUS_WIDTH-1:0] if_addr_i,
  output logic                 if_ready_o,
  output logic                 if_rvalid_o,
  output logic [BUS_WIDTH-1:0] if_rdata_o,
  // load/store requester
  input  logic                 ls_req_i,
  input  logic                 ls_wr_i,
  input  logic [BUS_WIDTH-1:0] ls_addr_i,
  input  logic [BUS_WIDTH-1:0] ls_wdata_i,
  output logic                 ls_ready_o,
  output logic                 ls_rvalid_o,
  output logic [BUS_WIDTH-1:0] ls_rdata_o,
  // memory side
  output logic                 mem_req_o,
  output logic                 mem_wr_o,
  output logic [BUS_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [BUS_WIDTH-1:0] mem_rdata_i,
  // status
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitIf, StWaitLs} state_e;

  state_e               state_q;
  logic [StarveW-1:0]   starve_q;
  logic [TmoW-1:0]      tmo_q;
  logic                 if_ready_q, if_rvalid_q, ls_ready_q, ls_rvalid_q;
  logic                 mem_req_q, mem_wr_q, err_q, busy_q;
  logic [BUS_WIDTH-1:0] if_rdata_q, ls_rdata_q, mem_addr_q, mem_wdata_q;
  logic                 grant_ls, grant_if;

  // LS has priority unless IF has waited through STARVE_LIMIT consecutive LS grants
  always_comb begin
    grant_ls = ls_req_i && !(if_req_i && (starve_q == StarveMax));
    grant_if = !grant_ls && if_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_ready_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_ready_q  <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_ready_q  <= 1'b0;
      ls_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if (!if_req_i) starve_q <= '0;

      unique case (state_q)
        StIdle: begin
          if (grant_ls) begin
            state_q     <= StWaitLs;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= ls_wr_i;
            mem_addr_q  <= ls_addr_i;
            mem_wdata_q <= ls_wdata_i;
            ls_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            tmo_q       <= '0;
            if (if_req_i && (starve_q != StarveMax)) starve_q <= starve_q + 1'b1;
          end else if (grant_if) begin
            state_q    <= StWaitIf;
            mem_req_q  <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
            if_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            tmo_q      <= '0;
            starve_q   <= '0;
          end
        end
        StWaitIf, StWaitLs: begin
          if (mem_ack_i) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            if (state_q == StWaitIf) begin
              if_rdata_q  <= mem_rdata_i;
              if_rvalid_q <= 1'b1;
            end else begin
              ls_rvalid_q <= 1'b1;
              if (!mem_wr_q) ls_rdata_q <= mem_rdata_i;
            end
          end else if (tmo_q == TmoLast) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_ready_o  = if_ready_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_ready_o  = ls_ready_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, reads, stores, priority,
// starvation limit, watchdog abort and reset during an access.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, ls_req_i, ls_wr_i, mem_ack_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
  logic        if_ready_o, if_rvalid_o, ls_ready_o, ls_rvalid_o;
  logic        mem_req_o, mem_wr_o, err_o, busy_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_rvalid;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .BUS_WIDTH   (32),
    .STARVE_LIMIT(4),
    .TIMEOUT     (64)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ready_o (if_ready_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .ls_req_i   (ls_req_i),
    .ls_wr_i    (ls_wr_i),
    .ls_addr_i  (ls_addr_i),
    .ls_wdata_i (ls_wdata_i),
    .ls_ready_o (ls_ready_o),
    .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o (ls_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_wr_o   (mem_wr_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock and sample just after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0040;
    ls_req_i    = 1'b0;
    ls_wr_i     = 1'b0;
    ls_addr_i   = '0;
    ls_wdata_i  = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    // reset held with if_req pending
    step();
    step();
    check_eq("rst_if_ready", if_ready_o, 0);
    check_eq("rst_if_rvalid", if_rvalid_o, 0);
    check_eq("rst_if_rdata", if_rdata_o, 0);
    check_eq("rst_ls_ready", ls_ready_o, 0);
    check_eq("rst_ls_rvalid", ls_rvalid_o, 0);
    check_eq("rst_ls_rdata", ls_rdata_o, 0);
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_mem_wr", mem_wr_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_mem_wdata", mem_wdata_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    step();
    check_eq("rel_if_ready", if_ready_o, 1);
    check_eq("rel_mem_req", mem_req_o, 1);
    check_eq("rel_mem_addr", mem_addr_o, 32'h40);
    check_eq("rel_mem_wr", mem_wr_o, 0);
    check_eq("rel_busy", busy_o, 1);
    if_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_0013;
    step();
    check_eq("rel_if_rvalid", if_rvalid_o, 1);
    check_eq("rel_if_rdata", if_rdata_o, 32'h13);
    mem_ack_i = 1'b0;
    step();

    // IF read with ack two cycles after grant
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0010;
    step();
    check_eq("rd_if_ready", if_ready_o, 1);
    check_eq("rd_mem_addr", mem_addr_o, 32'h10);
    if_req_i = 1'b0;
    step();
    check_eq("rd_ready_pulse", if_ready_o, 0);
    check_eq("rd_wait_req", mem_req_o, 1);
    check_eq("rd_wait_rvalid", if_rvalid_o, 0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0050_0093;
    step();
    check_eq("rd_rvalid", if_rvalid_o, 1);
    check_eq("rd_rdata", if_rdata_o, 32'h0050_0093);
    check_eq("rd_mem_req_low", mem_req_o, 0);
    check_eq("rd_busy_low", busy_o, 0);
    // stray ack while idle must be ignored
    mem_rdata_i = 32'hFFFF_FFFF;
    step();
    check_eq("rd_rvalid_pulse", if_rvalid_o, 0);
    check_eq("idle_ack_rdata", if_rdata_o, 32'h0050_0093);
    check_eq("idle_ack_busy", busy_o, 0);
    mem_ack_i = 1'b0;
    step();

    // simultaneous requests: LS store first, then IF
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0020;
    ls_req_i   = 1'b1;
    ls_wr_i    = 1'b1;
    ls_addr_i  = 32'h0000_0100;
    ls_wdata_i = 32'hDEAD_BEEF;
    step();
    check_eq("pri_ls_ready", ls_ready_o, 1);
    check_eq("pri_if_ready", if_ready_o, 0);
    check_eq("pri_mem_wr", mem_wr_o, 1);
    check_eq("pri_mem_addr", mem_addr_o, 32'h100);
    check_eq("pri_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    ls_req_i  = 1'b0;
    mem_ack_i = 1'b1;
    step();
    check_eq("st_ls_rvalid", ls_rvalid_o, 1);
    check_eq("st_ls_rdata_kept", ls_rdata_o, 0);
    check_eq("st_mem_wr_low", mem_wr_o, 0);
    check_eq("st_no_grant", if_ready_o, 0);
    check_eq("st_wdata_kept", mem_wdata_o, 32'hDEAD_BEEF);
    mem_ack_i = 1'b0;
    step();
    check_eq("pri_if_after", if_ready_o, 1);
    check_eq("pri_if_addr", mem_addr_o, 32'h20);
    check_eq("pri_if_wr", mem_wr_o, 0);
    if_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_0077;
    step();
    check_eq("pri_if_rdata", if_rdata_o, 32'h77);
    mem_ack_i = 1'b0;
    step();

    // starvation: LS held, IF pending -> 4 LS, 1 IF, then LS
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0080;
    ls_req_i  = 1'b1;
    ls_wr_i   = 1'b0;
    ls_addr_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("stv_ls_grant%0d", i), ls_ready_o, 1);
      check_eq($sformatf("stv_if_hold%0d", i), if_ready_o, 0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hA000_0000 + i;
      step();
      check_eq($sformatf("stv_ls_rdata%0d", i), ls_rdata_o, 32'hA000_0000 + i);
      mem_ack_i = 1'b0;
    end
    step();
    check_eq("stv_if_forced", if_ready_o, 1);
    check_eq("stv_ls_blocked", ls_ready_o, 0);
    check_eq("stv_if_addr", mem_addr_o, 32'h80);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_0099;
    step();
    check_eq("stv_if_rvalid", if_rvalid_o, 1);
    mem_ack_i = 1'b0;
    step();
    check_eq("stv_ls_again", ls_ready_o, 1);
    check_eq("stv_if_waits", if_ready_o, 0);
    if_req_i  = 1'b0;
    ls_req_i  = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h0000_5555;
    step();
    check_eq("stv_last_rdata", ls_rdata_o, 32'h5555);
    mem_ack_i = 1'b0;
    step();

    // watchdog: no ack for 64 wait cycles
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0300;
    step();
    check_eq("tmo_grant", if_ready_o, 1);
    if_req_i    = 1'b0;
    seen_rvalid = 1'b0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (if_rvalid_o || err_o || !mem_req_o) seen_rvalid = 1'b1;
    end
    check_eq("tmo_early_abort", seen_rvalid, 0);
    step();
    check_eq("tmo_err", err_o, 1);
    check_eq("tmo_mem_req", mem_req_o, 0);
    check_eq("tmo_no_rvalid", if_rvalid_o, 0);
    check_eq("tmo_busy", busy_o, 0);
    check_eq("tmo_rdata_kept", if_rdata_o, 32'h99);
    ls_req_i  = 1'b1;
    ls_wr_i   = 1'b0;
    ls_addr_i = 32'h0000_0304;
    step();
    check_eq("tmo_err_pulse", err_o, 0);
    check_eq("tmo_next_grant", ls_ready_o, 1);
    check_eq("tmo_next_addr", mem_addr_o, 32'h304);
    ls_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_1234;
    step();
    check_eq("tmo_next_rvalid", ls_rvalid_o, 1);
    check_eq("tmo_next_rdata", ls_rdata_o, 32'h1234);
    mem_ack_i = 1'b0;
    step();

    // reset asserted mid WAIT_LS, ls_req kept high
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h0000_0400;
    step();
    check_eq("mr_grant", ls_ready_o, 1);
    #3;
    rst_ni = 1'b0;
    #1;
    check_eq("mr_mem_req_async", mem_req_o, 0);
    check_eq("mr_busy_async", busy_o, 0);
    step();
    check_eq("mr_no_rvalid", ls_rvalid_o, 0);
    rst_ni = 1'b1;
    step();
    check_eq("mr_regrant", ls_ready_o, 1);
    check_eq("mr_regrant_addr", mem_addr_o, 32'h400);
    check_eq("mr_regrant_req", mem_req_o, 1);
    ls_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0000_BEEF;
    step();
    check_eq("mr_rvalid", ls_rvalid_o, 1);
    check_eq("mr_rdata", ls_rdata_o, 32'hBEEF);
    mem_ack_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
